alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand width (legal range 4..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 A  input  WIDTH  SHALL be operand A, captured on the accepting edge.
REQ-006 B  input  WIDTH  SHALL be operand B, captured on the accepting edge.
REQ-007 OP  input  3  SHALL be the opcode, captured on the accepting edge.
REQ-008 R  output  2*WIDTH  SHALL be the registered result, held until the next completion.
REQ-009 busy  output  1  SHALL be high while an accepted operation is in progress.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking R valid.
REQ-011 Z  output  1  SHALL be the zero flag (see Configuration).
REQ-012 C  output  1  SHALL be the carry/borrow flag (see Configuration).

Function
REQ-013 States SHALL be IDLE, EXEC, MUL; accept = IDLE and start high at a rising edge.
REQ-014 Accept SHALL latch A, B, OP, set busy, go to MUL if OP=010 else EXEC.
REQ-015 EXEC SHALL write R, assert done, drop busy and return to IDLE on the next edge (R valid 1 edge after accept).
REQ-016 OP 000 SHALL give R = A+B zero-extended (carry in bit WIDTH).
REQ-017 OP 001 SHALL give R = (A-B) mod 2^(2*WIDTH).
REQ-018 OP 010 SHALL give R = A*B unsigned, computed by shift-add, one multiplier bit per cycle, LSB first.
REQ-019 MUL SHALL run exactly WIDTH cycles; R valid and done high after the WIDTH-th edge following accept.
REQ-020 OP 011 SHALL give R = ~A zero-extended; B ignored.
REQ-021 OP 100/101/110 SHALL give R = A&B / A|B / A^B zero-extended.
REQ-022 OP 111 SHALL give R = 0.
REQ-023 start while busy SHALL be ignored; input changes while busy SHALL not affect the result.
REQ-024 done SHALL be high in the IDLE cycle after completion; start in that cycle SHALL be accepted (back-to-back).
REQ-025 R SHALL change only on completion edges; partial products SHALL stay in internal registers.

Reset
REQ-026 rst high SHALL immediately force IDLE, R=0, busy=0, done=0, Z=0, C=0, clearing internal operand and accumulator registers.
REQ-027 rst during MUL or EXEC SHALL abort the operation with no done pulse; first accept after rst release starts clean.

Configuration
REQ-028 Macro ALU_SEQ_FLAGS_EN defined: on each completion Z = (R==0), C = carry out (OP 000) or borrow A<B (OP 001), C=0 for other OPs; flags held until next completion.
REQ-029 Macro ALU_SEQ_FLAGS_EN undefined: flag logic SHALL be absent and Z, C tied to 0; all other behaviour identical.

Verification
REQ-030 WIDTH=8, OP=000, A=8, B=5, start one cycle -> done 1 edge after accept, R=13; A=255, B=100 -> R=355, C=1 (flags on).
REQ-031 OP=001: A=8, B=5 -> R=3, C=0; A=5, B=8 -> R=65533, C=1.
REQ-032 OP=010, A=255, B=100 -> busy 8 cycles, done exactly 8 edges after accept, R=25500; start pulsed mid-operation ignored.
REQ-033 OP=011, A=8 -> R=247; OP=110, A=5, B=5 -> R=0, Z=1 (flags on), Z=0 (flags off); OP=111 -> R=0.
REQ-034 rst asserted 4 cycles into a multiply -> busy=0, R=0, no done; next add 8+5 after release -> R=13.
REQ-035 Back-to-back: start held high across done cycle with OP=100, A=255, B=100 -> accepted immediately, R=100 one edge later.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic ops plus a WIDTH-cycle shift-add multiplier.
// Optional Z/C flag registers are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           OP,
    output logic [2*WIDTH-1:0]   R,
    output logic                 busy,
    output logic                 done,
    output logic                 Z,
    output logic                 C
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     r_q, r_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RW-1:0]     exec_res;
    logic [RW-1:0]     mul_step;

`ifdef ALU_SEQ_FLAGS_EN
    logic              z_q, z_d;
    logic              c_q, c_d;
`endif

    function automatic logic [RW-1:0] alu_exec(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        case (op)
            OP_ADD:  alu_exec = ax + bx;
            OP_SUB:  alu_exec = ax - bx;
            OP_NOT:  alu_exec = {{WIDTH{1'b0}}, ~a};
            OP_AND:  alu_exec = ax & bx;
            OP_OR:   alu_exec = ax | bx;
            OP_XOR:  alu_exec = ax ^ bx;
            default: alu_exec = '0;
        endcase
    endfunction

    assign exec_res = alu_exec(a_q[WIDTH-1:0], b_q, op_q);
    // a_q doubles as the left-shifting multiplicand; b_q shifts right to expose the next multiplier bit
    assign mul_step = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
        z_d     = z_q;
        c_d     = c_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = {{WIDTH{1'b0}}, A};
                    b_d     = B;
                    op_d    = OP;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (OP == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                r_d     = exec_res;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef ALU_SEQ_FLAGS_EN
                z_d = (exec_res == '0);
                if (op_q == OP_ADD) begin
                    c_d = exec_res[WIDTH];
                end else if (op_q == OP_SUB) begin
                    c_d = (a_q[WIDTH-1:0] < b_q);
                end else begin
                    c_d = 1'b0;
                end
`endif
            end
            MUL: begin
                acc_d = mul_step;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    r_d     = mul_step;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef ALU_SEQ_FLAGS_EN
                    z_d = (mul_step == '0);
                    c_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            z_q     <= 1'b0;
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_SEQ_FLAGS_EN
            z_q     <= z_d;
            c_q     <= c_d;
`endif
        end
    end

    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef ALU_SEQ_FLAGS_EN
    assign Z = z_q;
    assign C = c_q;
`else
    assign Z = 1'b0;
    assign C = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results, monitor pops on each done pulse.
module tb_alu_seq;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [2:0]       OP;
    logic [2*W-1:0]   R;
    logic             busy;
    logic             done;
    logic             Z;
    logic             C;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .OP    (OP),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .Z     (Z),
        .C     (C)
    );

    typedef struct {
        longint r;
        bit     z;
        bit     c;
        int     due;
    } exp_t;

    exp_t   sb[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    longint last_r = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model written straight from the opcode table.
    function automatic exp_t model(input int a, input int b, input int op, input int acc_cyc);
        exp_t   e;
        longint ua = a;
        longint ub = b;
        longint lim = 64'd1 << W;
        longint mask = (64'd1 << (2 * W)) - 1;
        bit     cy;
        case (op)
            0:       e.r = ua + ub;
            1:       e.r = (ua - ub) & mask;
            2:       e.r = ua * ub;
            3:       e.r = (lim - 1) - ua;
            4:       e.r = ua & ub;
            5:       e.r = ua | ub;
            6:       e.r = ua ^ ub;
            default: e.r = 0;
        endcase
        cy = (op == 0) ? (ua + ub >= lim) : (op == 1) ? (ua < ub) : 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
        e.z = (e.r == 0);
        e.c = cy;
`else
        e.z = 1'b0;
        e.c = 1'b0;
        if (cy) e.c = 1'b0;
`endif
        e.due = acc_cyc + ((op == 2) ? W : 1);
        return e;
    endfunction

    // Called at a negedge; waits for idle, issues one op, scrambles inputs while busy.
    task automatic issue(input int a, input int b, input int op);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
        A = W'(a);
        B = W'(b);
        OP = 3'(op);
        start = 1'b1;
        sb.push_back(model(a, b, op, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            A = W'($urandom);
            B = W'($urandom);
            OP = 3'($urandom);
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (busy) chk("op_timeout", 1, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_r = 0;
                chk("done_in_reset", done, 0);
            end else if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("R", R, e.r);
                    chk("Z", Z, e.z);
                    chk("C", C, e.c);
                    chk("latency", cyc, e.due);
                    chk("busy_at_done", busy, 0);
                end
                last_r = R;
            end else begin
                chk("R_hold", R, last_r);
            end
        end
    end

    // Driver
    initial begin
        int n;
        rst = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        OP = '0;
        #3 rst = 1'b1;
        #1;
        chk("rst_R", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_Z", Z, 0);
        chk("rst_C", C, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        issue(8, 5, 0);
        issue(255, 100, 0);
        issue(8, 5, 1);
        issue(5, 8, 1);
        issue(255, 100, 2);
        issue(8, 0, 3);
        issue(5, 5, 6);
        issue(77, 33, 7);
        issue(0, 200, 2);
        issue(255, 255, 2);

        // Reset four edges into a multiply: aborted, no done pulse.
        A = 8'd255;
        B = 8'd100;
        OP = 3'b010;
        start = 1'b1;
        sb.push_back(model(255, 100, 2, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_R", R, 0);
        chk("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        issue(8, 5, 0);

        // Back-to-back: start held through the done cycle.
        A = 8'd255;
        B = 8'd100;
        OP = 3'b100;
        start = 1'b1;
        sb.push_back(model(255, 100, 4, cyc + 1));
        @(negedge clk);
        chk("b2b_busy_exec", busy, 1);
        @(negedge clk);
        chk("b2b_done_cycle", done, 1);
        sb.push_back(model(255, 100, 4, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_busy", busy, 1);
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 7)));
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
